// File: rtl/texture_sprite_render.sv
// Scaled 16x16 texture sprite over a raster stream; 3-cycle pixel pipeline around a 1-cycle pROM.
// Define SPRITE_BOUNCE_EN to make the sprite bounce around the active area once per frame.
module texture_sprite_render #(
  parameter int          H_ACT       = 1280,
  parameter int          V_ACT       = 720,
  parameter int          SPRITE_X    = 100,
  parameter int          SPRITE_Y    = 100,
  parameter int          SCALE_SHIFT = 2,
  parameter int          SPEED       = 2,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic        in_de,
  input  logic [11:0] in_x,
  input  logic [11:0] in_y,
  output logic [7:0]  rom_ad,
  output logic        rom_ce,
  output logic        rom_oce,
  output logic        rom_reset,
  input  logic [23:0] rom_dout,
  output logic        out_hs,
  output logic        out_vs,
  output logic        out_de,
  output logic [23:0] out_rgb
);

  localparam int          S   = 16 << SCALE_SHIFT;
  localparam logic [11:0] S12 = 12'(S);

  generate
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3 || S > H_ACT || S > V_ACT || SPEED < 0) begin : g_bad_cfg
      $error("texture_sprite_render: sprite does not fit the active area or bad scale/speed");
    end
  endgenerate

  assign rom_reset = ~rst_n;
  assign rom_ce    = rst_n;
  assign rom_oce   = rst_n;

  logic [11:0] w_pos_x;
  logic [11:0] w_pos_y;

`ifdef SPRITE_BOUNCE_EN
  localparam logic [12:0] LIM_X = 13'(H_ACT - S);
  localparam logic [12:0] LIM_Y = 13'(V_ACT - S);
  localparam logic [12:0] SPD   = 13'(SPEED);

  logic [11:0] r_pos_x;
  logic [11:0] r_pos_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_vs_d;

  // Returns {dir, pos}; dir=1 means moving toward larger coordinates. Reaching an
  // edge flips direction in the same update so the next frame already moves away.
  function automatic logic [12:0] next_axis(input logic [11:0] p, input logic d,
                                             input logic [12:0] lim);
    logic [12:0] nx;
    logic [12:0] res;
    res = {d, p};
    if (d) begin
      nx = {1'b0, p} + SPD;
      if (nx >= lim) res = {1'b0, lim[11:0]};
      else           res = {1'b1, nx[11:0]};
    end else begin
      if ({1'b0, p} <= SPD) res = {1'b1, 12'd0};
      else                  res = {1'b0, p - SPD[11:0]};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pos_x <= 12'(SPRITE_X);
      r_pos_y <= 12'(SPRITE_Y);
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
      r_vs_d  <= 1'b0;
    end else begin
      r_vs_d <= in_vs;
      if (in_vs && !r_vs_d) begin
        {r_dir_x, r_pos_x} <= next_axis(r_pos_x, r_dir_x, LIM_X);
        {r_dir_y, r_pos_y} <= next_axis(r_pos_y, r_dir_y, LIM_Y);
      end
    end
  end

  assign w_pos_x = r_pos_x;
  assign w_pos_y = r_pos_y;
`else
  assign w_pos_x = 12'(SPRITE_X);
  assign w_pos_y = 12'(SPRITE_Y);
`endif

  // Unsigned offsets: coordinates left of / above the sprite wrap large and miss.
  logic [11:0] w_dx;
  logic [11:0] w_dy;
  logic        w_hit;
  logic [3:0]  w_col;
  logic [3:0]  w_row;

  assign w_dx  = in_x - w_pos_x;
  assign w_dy  = in_y - w_pos_y;
  assign w_hit = in_de && (w_dx < S12) && (w_dy < S12);
  assign w_col = 4'(w_dx >> SCALE_SHIFT);
  assign w_row = 4'(w_dy >> SCALE_SHIFT);

  logic [7:0]  r_rom_ad;
  logic        r_hit1, r_hs1, r_vs1, r_de1;
  logic        r_hit2, r_hs2, r_vs2, r_de2;
  logic        r_out_hs, r_out_vs, r_out_de;
  logic [23:0] r_out_rgb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rom_ad  <= 8'd0;
      r_hit1    <= 1'b0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_de1     <= 1'b0;
      r_hit2    <= 1'b0;
      r_hs2     <= 1'b0;
      r_vs2     <= 1'b0;
      r_de2     <= 1'b0;
      r_out_hs  <= 1'b0;
      r_out_vs  <= 1'b0;
      r_out_de  <= 1'b0;
      r_out_rgb <= 24'd0;
    end else begin
      // Address only moves on hits so the pROM address bus stays quiet elsewhere.
      if (w_hit) r_rom_ad <= {w_row, w_col};
      r_hit1 <= w_hit;
      r_hs1  <= in_hs;
      r_vs1  <= in_vs;
      r_de1  <= in_de;

      r_hit2 <= r_hit1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_de2  <= r_de1;

      r_out_hs  <= r_hs2;
      r_out_vs  <= r_vs2;
      r_out_de  <= r_de2;
      r_out_rgb <= (r_hit2 && r_de2) ? rom_dout : (r_de2 ? BG_COLOR : 24'd0);
    end
  end

  assign rom_ad  = r_rom_ad;
  assign out_hs  = r_out_hs;
  assign out_vs  = r_out_vs;
  assign out_de  = r_out_de;
  assign out_rgb = r_out_rgb;

endmodule

// File: tb/tb_texture_sprite_render.sv
// Directed bench for texture_sprite_render with a behavioural 1-cycle pROM.
// Bounce checks are compiled only when SPRITE_BOUNCE_EN is defined.
module tb_texture_sprite_render;

  localparam logic [23:0] BG = 24'h123456;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_hs, in_vs, in_de;
  logic [11:0] in_x, in_y;
  logic [7:0]  rom_ad;
  logic        rom_ce, rom_oce, rom_reset;
  logic [23:0] rom_dout;
  logic        out_hs, out_vs, out_de;
  logic [23:0] out_rgb;

  int checks = 0;
  int errors = 0;

  texture_sprite_render #(.BG_COLOR(BG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_x(in_x), .in_y(in_y),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_dout(rom_dout),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb)
  );

  always #5 clk = ~clk;

  // Texture pROM: texel(i) = {i, ~i, 3C}, except the two texels named in the test plan.
  logic [23:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i), 8'h3C};
    mem[0] = 24'h00ADA0;
    mem[7] = 24'h00BFB5;
  end

  always @(posedge clk) begin
    if (rom_reset)   rom_dout <= 24'd0;
    else if (rom_ce) rom_dout <= mem[rom_ad];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic de,
                       input logic [11:0] x, input logic [11:0] y);
    in_hs = hs; in_vs = vs; in_de = de; in_x = x; in_y = y;
  endtask

  typedef struct {
    logic        hs, vs, de;
    logic [11:0] x, y;
    logic [7:0]  exp_ad;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [13];

`ifdef SPRITE_BOUNCE_EN
  typedef struct {
    int          k;
    logic [11:0] px;
    logic        dx;
    logic [11:0] py;
    logic        dy;
  } cp_t;
  cp_t cps [10];
`endif

  initial begin
    // Sprite window is x,y in [100,163], texel = offset>>2.
    vecs[0]  = '{0, 0, 1, 12'd100, 12'd100, 8'h00, 24'h00ADA0};
    vecs[1]  = '{0, 0, 1, 12'd128, 12'd100, 8'h07, 24'h00BFB5};
    vecs[2]  = '{0, 0, 1, 12'd99,  12'd100, 8'h07, BG};
    vecs[3]  = '{0, 0, 1, 12'd164, 12'd100, 8'h07, BG};
    vecs[4]  = '{0, 0, 1, 12'd163, 12'd163, 8'hFF, 24'hFF003C};
    vecs[5]  = '{0, 0, 1, 12'd105, 12'd140, 8'hA1, 24'hA15E3C};
    vecs[6]  = '{0, 0, 1, 12'd100, 12'd99,  8'hA1, BG};
    vecs[7]  = '{0, 0, 0, 12'd100, 12'd100, 8'hA1, 24'h000000};
    vecs[8]  = '{0, 0, 1, 12'd110, 12'd164, 8'hA1, BG};
    vecs[9]  = '{1, 0, 0, 12'd0,   12'd0,   8'hA1, 24'h000000};
    vecs[10] = '{0, 1, 0, 12'd0,   12'd0,   8'hA1, 24'h000000};
    vecs[11] = '{1, 1, 0, 12'd0,   12'd0,   8'hA1, 24'h000000};
    vecs[12] = '{0, 0, 0, 12'd0,   12'd0,   8'hA1, 24'h000000};

    // Reset hold
    rst_n = 1'b0;
    drive(0, 0, 0, 12'd0, 12'd0);
    step(); step(); step();
    check("reset out_rgb", 32'(out_rgb), 32'h0);
    check("reset out_hs/vs/de", {29'd0, out_hs, out_vs, out_de}, 32'h0);
    check("reset rom_ad", 32'(rom_ad), 32'h0);
    check("reset rom_reset", 32'(rom_reset), 32'h1);
    check("reset rom_ce/oce", {30'd0, rom_ce, rom_oce}, 32'h0);

    rst_n = 1'b1;
    #1;
    check("run rom_reset", 32'(rom_reset), 32'h0);
    check("run rom_ce/oce", {30'd0, rom_ce, rom_oce}, 32'h3);
    step(); step();
    check("idle out_de", 32'(out_de), 32'h0);

    // Streamed table: rom_ad one cycle after input, outputs three cycles after input.
    for (int i = 0; i < 15; i++) begin
      if (i < 13) drive(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].x, vecs[i].y);
      else        drive(0, 0, 0, 12'd0, 12'd0);
      step();
      if (i < 13) check($sformatf("vec%0d rom_ad", i), 32'(rom_ad), 32'(vecs[i].exp_ad));
      if (i >= 2) begin
        check($sformatf("vec%0d out_rgb", i - 2), 32'(out_rgb), 32'(vecs[i-2].exp_rgb));
        check($sformatf("vec%0d out_hs/vs/de", i - 2), {29'd0, out_hs, out_vs, out_de},
              {29'd0, vecs[i-2].hs, vecs[i-2].vs, vecs[i-2].de});
      end
    end

    // Mid-line reset: move sprite (if it can), stream hits, pulse reset for one cycle.
    for (int j = 0; j < 3; j++) begin
      drive(0, 1, 0, 12'd0, 12'd0); step();
      drive(0, 0, 0, 12'd0, 12'd0); step();
    end
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 1, 12'(100 + 4 * j), 12'd104);
      step();
    end
    check("pre-reset out_de", 32'(out_de), 32'h1);
    rst_n = 1'b0;
    drive(1, 1, 1, 12'd112, 12'd104);
    step();
    check("midreset out_rgb", 32'(out_rgb), 32'h0);
    check("midreset out_hs/vs/de", {29'd0, out_hs, out_vs, out_de}, 32'h0);
    check("midreset rom_ad", 32'(rom_ad), 32'h0);
    rst_n = 1'b1;
    drive(0, 0, 0, 12'd0, 12'd0);
    step();
    check("flush1 out_rgb", 32'(out_rgb), 32'h0);
    check("flush1 out_hs/vs/de", {29'd0, out_hs, out_vs, out_de}, 32'h0);
    step();
    check("flush2 out_rgb", 32'(out_rgb), 32'h0);
    check("flush2 out_hs/vs/de", {29'd0, out_hs, out_vs, out_de}, 32'h0);

    // Position must be back at (100,100)
    drive(0, 0, 1, 12'd100, 12'd100);
    step();
    check("postreset rom_ad", 32'(rom_ad), 32'h00);
    drive(0, 0, 1, 12'd99, 12'd100);
    step();
    drive(0, 0, 0, 12'd0, 12'd0);
    step();
    check("postreset hit out_rgb", 32'(out_rgb), 32'h00ADA0);
    check("postreset hit out_de", 32'(out_de), 32'h1);
    step();
    check("postreset miss out_rgb", 32'(out_rgb), 32'(BG));

`ifdef SPRITE_BOUNCE_EN
    // Hand-computed positions after k vsync rising edges from (100,100), moving +2/frame.
    cps[0] = '{1,   12'd102,  1'b1, 12'd102, 1'b1};
    cps[1] = '{277, 12'd654,  1'b1, 12'd654, 1'b1};
    cps[2] = '{278, 12'd656,  1'b1, 12'd656, 1'b0};
    cps[3] = '{279, 12'd658,  1'b1, 12'd654, 1'b0};
    cps[4] = '{557, 12'd1214, 1'b1, 12'd98,  1'b0};
    cps[5] = '{558, 12'd1216, 1'b0, 12'd96,  1'b0};
    cps[6] = '{559, 12'd1214, 1'b0, 12'd94,  1'b0};
    cps[7] = '{605, 12'd1122, 1'b0, 12'd2,   1'b0};
    cps[8] = '{606, 12'd1120, 1'b0, 12'd0,   1'b1};
    cps[9] = '{607, 12'd1118, 1'b0, 12'd2,   1'b1};

    rst_n = 1'b0;
    drive(0, 0, 0, 12'd0, 12'd0);
    step();
    rst_n = 1'b1;
    begin
      int c;
      c = 0;
      for (int k = 1; k <= 607; k++) begin
        drive(0, 1, 0, 12'd0, 12'd0); step();
        drive(0, 0, 0, 12'd0, 12'd0); step();
        if (c < 10 && cps[c].k == k) begin
          check($sformatf("bounce k=%0d pos_x", k), 32'(dut.r_pos_x), 32'(cps[c].px));
          check($sformatf("bounce k=%0d dir_x", k), 32'(dut.r_dir_x), 32'(cps[c].dx));
          check($sformatf("bounce k=%0d pos_y", k), 32'(dut.r_pos_y), 32'(cps[c].py));
          check($sformatf("bounce k=%0d dir_y", k), 32'(dut.r_dir_y), 32'(cps[c].dy));
          c++;
        end
      end
    end
    // Sprite now at (1118,2): its top-left pixel must hit texel 0.
    drive(0, 0, 1, 12'd1118, 12'd2);
    step();
    check("bounce final rom_ad", 32'(rom_ad), 32'h00);
    drive(0, 0, 0, 12'd0, 12'd0);
    step(); step();
    check("bounce final out_rgb", 32'(out_rgb), 32'h00ADA0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
